// File: rtl/atax_mem_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM master port between the atax A/x/y masters.
// Optional per-master completed-transfer counters are enabled by defining ATAX_ARB_PERF_EN.
module atax_mem_arbiter #(
  parameter int BUS_SIZE  = 64,
  parameter int BUS_BYTES = 8,
  parameter int ADDR_W    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 avs_A_read,
  input  logic                 avs_A_write,
  input  logic [ADDR_W-1:0]    avs_A_address,
  input  logic [BUS_SIZE-1:0]  avs_A_writedata,
  input  logic [BUS_BYTES-1:0] avs_A_byteenable,
  output logic [BUS_SIZE-1:0]  avs_A_readdata,
  output logic                 avs_A_waitrequest,
  input  logic                 avs_x_read,
  input  logic                 avs_x_write,
  input  logic [ADDR_W-1:0]    avs_x_address,
  input  logic [BUS_SIZE-1:0]  avs_x_writedata,
  input  logic [BUS_BYTES-1:0] avs_x_byteenable,
  output logic [BUS_SIZE-1:0]  avs_x_readdata,
  output logic                 avs_x_waitrequest,
  input  logic                 avs_y_read,
  input  logic                 avs_y_write,
  input  logic [ADDR_W-1:0]    avs_y_address,
  input  logic [BUS_SIZE-1:0]  avs_y_writedata,
  input  logic [BUS_BYTES-1:0] avs_y_byteenable,
  output logic [BUS_SIZE-1:0]  avs_y_readdata,
  output logic                 avs_y_waitrequest,
  output logic                 avm_mem_read,
  output logic                 avm_mem_write,
  output logic [ADDR_W-1:0]    avm_mem_address,
  output logic [BUS_SIZE-1:0]  avm_mem_writedata,
  output logic [BUS_BYTES-1:0] avm_mem_byteenable,
  input  logic [BUS_SIZE-1:0]  avm_mem_readdata,
  input  logic                 avm_mem_waitrequest,
  output logic [31:0]          perf_cnt_A,
  output logic [31:0]          perf_cnt_x,
  output logic [31:0]          perf_cnt_y
);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  localparam logic [1:0] G_A    = 2'd0;
  localparam logic [1:0] G_X    = 2'd1;
  localparam logic [1:0] G_Y    = 2'd2;
  localparam logic [1:0] G_NONE = 2'd3;

  state_t     r_state;
  state_t     w_nextState;
  logic [1:0] r_grant;
  logic [1:0] w_nextGrant;
  logic [1:0] r_lastGrant;
  logic [1:0] w_pick;
  logic [2:0] w_req;
  logic       w_gRead;
  logic       w_gWrite;
  logic       w_gReq;
  logic       w_done;

  assign w_req = {avs_y_read | avs_y_write, avs_x_read | avs_x_write, avs_A_read | avs_A_write};
  assign w_gReq = w_gRead | w_gWrite;

  assign avs_A_readdata = avm_mem_readdata;
  assign avs_x_readdata = avm_mem_readdata;
  assign avs_y_readdata = avm_mem_readdata;

  // Data path follows the registered grant; it is a don't-care while idle.
  always_comb begin
    w_gRead            = 1'b0;
    w_gWrite           = 1'b0;
    avm_mem_address    = avs_A_address;
    avm_mem_writedata  = avs_A_writedata;
    avm_mem_byteenable = avs_A_byteenable;
    case (r_grant)
      G_A: begin
        w_gRead  = avs_A_read;
        w_gWrite = avs_A_write;
      end
      G_X: begin
        w_gRead            = avs_x_read;
        w_gWrite           = avs_x_write;
        avm_mem_address    = avs_x_address;
        avm_mem_writedata  = avs_x_writedata;
        avm_mem_byteenable = avs_x_byteenable;
      end
      G_Y: begin
        w_gRead            = avs_y_read;
        w_gWrite           = avs_y_write;
        avm_mem_address    = avs_y_address;
        avm_mem_writedata  = avs_y_writedata;
        avm_mem_byteenable = avs_y_byteenable;
      end
      default: ;
    endcase
  end

  // Search starts just after the last completed grant, wrapping A->x->y->A.
  always_comb begin
    w_pick = G_A;
    case (r_lastGrant)
      G_A:     w_pick = w_req[1] ? G_X : (w_req[2] ? G_Y : G_A);
      G_X:     w_pick = w_req[2] ? G_Y : (w_req[0] ? G_A : G_X);
      default: w_pick = w_req[0] ? G_A : (w_req[1] ? G_X : G_Y);
    endcase
  end

  always_comb begin
    w_nextState       = r_state;
    w_nextGrant       = r_grant;
    w_done            = 1'b0;
    avs_A_waitrequest = 1'b1;
    avs_x_waitrequest = 1'b1;
    avs_y_waitrequest = 1'b1;
    avm_mem_read      = 1'b0;
    avm_mem_write     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_req) begin
          w_nextState = S_BUSY;
          w_nextGrant = w_pick;
        end
      end
      S_BUSY: begin
        case (r_grant)
          G_A:     avs_A_waitrequest = avm_mem_waitrequest;
          G_X:     avs_x_waitrequest = avm_mem_waitrequest;
          G_Y:     avs_y_waitrequest = avm_mem_waitrequest;
          default: ;
        endcase
        avm_mem_write = w_gWrite;
        avm_mem_read  = w_gRead & ~w_gWrite;
        // A master abandoning its request releases the bus without credit.
        if (!w_gReq) begin
          w_nextState = S_IDLE;
          w_nextGrant = G_NONE;
        end else if (!avm_mem_waitrequest) begin
          w_done      = 1'b1;
          w_nextState = S_IDLE;
          w_nextGrant = G_NONE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_grant     <= G_NONE;
      r_lastGrant <= G_Y;
    end else begin
      r_state <= w_nextState;
      r_grant <= w_nextGrant;
      if (w_done) r_lastGrant <= r_grant;
    end
  end

`ifdef ATAX_ARB_PERF_EN
  logic [31:0] r_perfA;
  logic [31:0] r_perfX;
  logic [31:0] r_perfY;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_perfA <= '0;
      r_perfX <= '0;
      r_perfY <= '0;
    end else if (w_done) begin
      case (r_grant)
        G_A:     r_perfA <= r_perfA + 32'd1;
        G_X:     r_perfX <= r_perfX + 32'd1;
        G_Y:     r_perfY <= r_perfY + 32'd1;
        default: ;
      endcase
    end
  end

  assign perf_cnt_A = r_perfA;
  assign perf_cnt_x = r_perfX;
  assign perf_cnt_y = r_perfY;
`else
  assign perf_cnt_A = '0;
  assign perf_cnt_x = '0;
  assign perf_cnt_y = '0;
`endif

endmodule
